seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Programmable serial sequence-detector controller: accepts a pattern configuration (bits, length, overlap mode, match limit) through a valid/ready handshake and arms or stops detection on command. It emits a Mealy match pulse and counts matches, then stops automatically when the configured limit is reached. It generalises the fixed 1011 Mealy detectors to a run-time-configured, sequenced block that sits between a serial bit source and a host/test sequencer.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and limit

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted (IDLE or DONE)
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is first bit received, bit [0] is last
cfg_len  input  $clog2(MAX_LEN+1)  pattern length, legal 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_limit  input  CNT_W  matches before auto-stop; 0 = unlimited
start  input  1  arm detection (1-cycle pulse)
stop  input  1  abort detection (1-cycle pulse)
din_valid  input  1  din qualifies this cycle
din  input  1  serial data bit
dout  output  1  Mealy match pulse, combinational on din in the matching cycle
match_count  output  CNT_W  matches since last start
busy  output  1  high in RUN
done  output  1  high in DONE (limit reached)
err  output  1  sticky illegal-config flag

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE. hist, fill, match_count, err, done = 0. Stored config: len=0 (invalid), pattern=0, overlap=0, limit=0. dout=0, busy=0, cfg_ready=1.
- States: IDLE, RUN, DONE. cfg_ready = (state != RUN).
- Config: accepted when cfg_valid & cfg_ready at the edge. If cfg_len is 0 or > MAX_LEN, the config is rejected (stored config unchanged) and err is set. A legal config is latched and clears err. Accepting a config in DONE returns the block to IDLE and clears done.
- Config and start in the same cycle: the config is latched and start is ignored.
- start in IDLE or DONE with a valid stored len (and no config accepted that cycle): go to RUN; clear match_count, fill, hist and done. start in RUN is ignored.
- stop in RUN: go to IDLE next edge; match_count is held. stop has priority over a match in the same cycle: that match is not counted and dout is forced 0. stop outside RUN is ignored.
- Datapath in RUN:
  - On each din_valid cycle, shift din into hist (MAX_LEN-1 bits, din enters at LSB).
  - fill increments, saturating at MAX_LEN-1.
  - Cycles without din_valid leave all datapath state unchanged.
- Match (combinational): dout = RUN & din_valid & ~stop & (fill >= len-1) & ({hist[len-2:0],din} == pattern[len-1:0]). For len=1, compare din alone.
- On a match:
  - match_count increments, saturating at all-ones.
  - Non-overlap mode: fill is cleared to 0 instead of incremented; hist is still shifted.
  - Overlap mode: fill updates normally.
- Limit: if limit != 0 and the incremented count equals limit, go to DONE on the same edge. done=1 and busy=0 from the next cycle. dout is 0 in DONE.
- busy = (state==RUN); done = (state==DONE). Both are registered decodes.
- match_count holds its value in IDLE and DONE until the next start or reset.
- Reset during RUN aborts immediately, with all values as listed under Reset.

Test Plan:
1. Reset, then cfg pattern=1011 len=4 overlap=1 limit=0, start. Feed din_valid=1 with bits 0,0,1,0,1,0,1,0,1,1,0,1,1 -> dout pulses on bits 10 and 13 (1-based); match_count=2; busy=1.
2. Same stream, overlap=0 -> single dout on bit 10; match_count=1 (bits 11..13 alone do not match).
3. pattern=1010 len=4 overlap=1 limit=2, same stream -> matches on bits 6 and 8. State goes to DONE at the bit-8 edge; done=1, busy=0, cfg_ready=1; later bits produce no dout; count=2.
4. cfg_len=0, then cfg_len=MAX_LEN+1 -> err=1 and stored config unchanged. A following legal config clears err. start with no legal config after reset -> stays IDLE.
5. Run with 1011. Deassert din_valid for 3 cycles between bits 1,0,1 and 1 -> still one match. Assert stop on the matching cycle -> dout=0, count unchanged, IDLE next cycle.
6. Assert rst=0 mid-RUN with count=1 -> next cycle IDLE, count=0, busy=0, err=0. cfg_valid together with start in IDLE -> config latched, state remains IDLE.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector with config handshake, start/stop and match-limit auto-stop.
// Latency: dout is combinational on din in the matching cycle; status/count update on the next edge.
// Backpressure: cfg_ready is low only in RUN; din has no backpressure and is sampled when din_valid.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   cfg_valid/cfg_ready      config handshake; cfg_pattern/cfg_len/cfg_overlap/cfg_limit payload
//   start, stop              one-cycle arm / abort commands
//   din_valid, din           serial bit stream
//   dout                     Mealy match pulse
//   match_count              matches since last start
//   busy, done, err          RUN state, DONE state, sticky illegal-config flag
module seq_det_ctrl #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_limit,
  input  logic               start,
  input  logic               stop,
  input  logic               din_valid,
  input  logic               din,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] MAXL     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

  state_t               state_q;
  logic [MAX_LEN-1:0]   pat_q;
  logic [LEN_W-1:0]     len_q;
  logic                 ovl_q;
  logic [CNT_W-1:0]     lim_q;
  logic [MAX_LEN-2:0]   hist_q;
  logic [LEN_W-1:0]     fill_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 err_q;

  logic [MAX_LEN-1:0]   window;
  logic [MAX_LEN-1:0]   mask;
  logic [MAX_LEN-2:0]   hist_d;
  logic [LEN_W-1:0]     fill_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 hit;
  logic                 cfg_acc;
  logic                 cfg_legal;

  always_comb begin
    // Newest bit sits at the LSB, so the last len bits are window[len-1:0].
    window    = {hist_q, din};
    // Shifting an all-ones vector by len clears exactly the low len bits; len==MAX_LEN yields all ones.
    mask      = ~({MAX_LEN{1'b1}} << len_q);
    hist_d    = window[MAX_LEN-2:0];
    fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    cfg_acc   = cfg_valid && (state_q != S_RUN);
    cfg_legal = (cfg_len != '0) && (cfg_len <= MAXL);
    hit       = (state_q == S_RUN) && din_valid && !stop &&
                (fill_q >= len_q - LEN_W'(1)) &&
                ((window & mask) == (pat_q & mask));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      lim_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (cfg_acc) begin
            // Config wins over a simultaneous start; any accepted config leaves DONE.
            if (cfg_legal) begin
              pat_q <= cfg_pattern;
              len_q <= cfg_len;
              ovl_q <= cfg_overlap;
              lim_q <= cfg_limit;
              err_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end else if (start && (len_q != '0)) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            fill_q  <= '0;
            hist_q  <= '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (din_valid) begin
            hist_q <= hist_d;
            if (hit) begin
              cnt_q  <= cnt_d;
              // Non-overlap: bits consumed by this match cannot start the next one.
              fill_q <= ovl_q ? fill_d : '0;
              if ((lim_q != '0) && (cnt_d == lim_q)) state_q <= S_DONE;
            end else begin
              fill_q <= fill_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout        = hit;
  assign match_count = cnt_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign cfg_ready   = (state_q != S_RUN);
  assign err         = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clk = 0;
  logic rst, cfg_valid, cfg_ready, cfg_overlap, start, stop, din_valid, din;
  logic dout, busy, done, err;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_limit, match_count;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_limit(cfg_limit), .start(start), .stop(stop), .din_valid(din_valid),
    .din(din), .dout(dout), .match_count(match_count), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic last_dout;

  // Reference model: 0=IDLE 1=RUN 2=DONE; bits usable for the next match kept in a queue.
  int   m_state, m_len, m_cnt, m_lim;
  logic [MAX_LEN-1:0] m_pat;
  bit   m_ovl, m_err;
  bit   q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    bit b;
    if (m_state != 1 || !din_valid || stop) return 0;
    if (q.size() < m_len - 1) return 0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == m_len - 1) ? din : q[q.size() - (m_len - 1) + i];
      if (b != m_pat[m_len-1-i]) return 0;
    end
    return 1;
  endfunction

  task automatic model_update();
    bit h;
    h = model_hit();
    if (!rst) begin
      m_state = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_lim = 0; m_cnt = 0; m_err = 0;
      q.delete();
    end else if (m_state != 1 && cfg_valid) begin
      if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
        m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap; m_lim = cfg_limit; m_err = 0;
      end else m_err = 1;
      m_state = 0;
    end else if (m_state != 1 && start && m_len != 0) begin
      m_state = 1; m_cnt = 0; q.delete();
    end else if (m_state == 1) begin
      if (stop) m_state = 0;
      else if (din_valid) begin
        q.push_back(din);
        if (q.size() > 2 * MAX_LEN) void'(q.pop_front());
        if (h) begin
          if (m_cnt != (1 << CNT_W) - 1) m_cnt++;
          if (!m_ovl) q.delete();
          if (m_lim != 0 && m_cnt == m_lim) m_state = 2;
        end
      end
    end
  endtask

  // One clock: check Mealy output mid-cycle, advance model, check registered outputs after the edge.
  task automatic step();
    @(negedge clk);
    last_dout = dout;
    check("dout", dout, model_hit());
    model_update();
    @(posedge clk);
    #1;
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("cfg_ready", cfg_ready, m_state != 1);
    check("match_count", match_count, m_cnt);
    check("err", err, m_err);
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; start = 0; stop = 0; din_valid = 0; din = 0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input int l, input bit ov, input int lim);
    cfg_valid = 1; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = ov; cfg_limit = CNT_W'(lim);
    step();
    idle_inputs();
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
  endtask

  task automatic feed(input logic b);
    din_valid = 1; din = b; step(); din_valid = 0;
  endtask

  typedef struct {
    logic d;
    logic exp_dout;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;
  vec_t vecs[13];
  logic [12:0] stream;

  initial begin
    stream = 13'b0010101011011;
    for (int i = 0; i < 13; i++) begin
      vecs[i].d        = stream[12-i];
      vecs[i].exp_dout = (i == 9 || i == 12);
      vecs[i].exp_cnt  = (i >= 12) ? 8'd2 : (i >= 9) ? 8'd1 : 8'd0;
    end

    rst = 0; idle_inputs(); cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_limit = 0;
    step(); step();
    rst = 1;

    // 1: overlapping 1011, table-driven
    do_cfg(8'b1011, 4, 1, 0);
    do_start();
    for (int i = 0; i < 13; i++) begin
      feed(vecs[i].d);
      check("t1_dout_tbl", last_dout, vecs[i].exp_dout);
      check("t1_cnt_tbl", match_count, vecs[i].exp_cnt);
    end
    check("t1_busy", busy, 1);

    // 2: non-overlapping
    stop = 1; step(); stop = 0;
    do_cfg(8'b1011, 4, 0, 0);
    do_start();
    for (int i = 0; i < 13; i++) feed(vecs[i].d);
    check("t2_cnt", match_count, 1);

    // 3: limit auto-stop
    stop = 1; step(); stop = 0;
    do_cfg(8'b1010, 4, 1, 2);
    do_start();
    for (int i = 0; i < 13; i++) feed(vecs[i].d);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_cnt", match_count, 2);

    // 4: illegal configs, start with no legal config after reset
    rst = 0; step(); rst = 1;
    do_start();
    check("t4_idle", busy, 0);
    do_cfg(8'hFF, 0, 1, 0);
    check("t4_err0", err, 1);
    do_cfg(8'hFF, MAX_LEN + 1, 1, 0);
    check("t4_err9", err, 1);
    do_start();
    check("t4_still_idle", busy, 0);
    do_cfg(8'b1011, 4, 1, 0);
    check("t4_err_clr", err, 0);

    // 5: gaps in din_valid, then stop on matching cycle
    do_start();
    feed(1); feed(0); feed(1);
    step(); step(); step();
    feed(1);
    check("t5_cnt", match_count, 1);
    feed(0); feed(1);
    din_valid = 1; din = 1; stop = 1; step(); idle_inputs();
    check("t5_stop_dout", last_dout, 0);
    check("t5_stop_cnt", match_count, 1);
    check("t5_stop_idle", busy, 0);

    // 6: reset mid-RUN, then config+start together
    do_cfg(8'h00, 12, 0, 0);
    do_start();
    feed(1); feed(0); feed(1); feed(1);
    rst = 0; step(); rst = 1;
    check("t6_cnt", match_count, 0);
    check("t6_err", err, 0);
    cfg_valid = 1; cfg_pattern = 8'b11; cfg_len = 2; cfg_overlap = 1; cfg_limit = 0; start = 1;
    step(); idle_inputs();
    check("t6_cfg_start_idle", busy, 0);

    // Randomized against the model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) != 0);
      cfg_valid   = ($urandom_range(0, 15) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(9, 15))
                                                : LEN_W'($urandom_range(0, 4));
      cfg_overlap = 1'($urandom);
      cfg_limit   = CNT_W'($urandom_range(0, 3));
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 49) == 0);
      din_valid   = ($urandom_range(0, 3) != 0);
      din         = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
